// File: rtl/ysyx_22050019_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter.
// The IFU and LSU share a single memory read port, and only one read is in
// flight at a time. The LSU has fixed priority. A starvation streak counter
// hands the IFU a contested grant after STARVE_MAX contested LSU wins in a row.
module ysyx_22050019_rd_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,        // active-high synchronous reset

  input  logic        ifu_arvalid,
  input  logic [63:0] ifu_araddr,
  output logic        ifu_arready,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [63:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,

  input  logic        lsu_arvalid,
  input  logic [63:0] lsu_araddr,
  output logic        lsu_arready,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [63:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,

  output logic        s_arvalid,
  output logic [63:0] s_araddr,
  input  logic        s_arready,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [63:0] s_rdata,
  input  logic [1:0]  s_rresp,

  output logic [1:0]  grant_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFU_AR = 3'd1,
    IFU_R  = 3'd2,
    LSU_AR = 3'd3,
    LSU_R  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;

  // State and starvation counter registers; reset returns straight to IDLE.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Next-state logic: arbitration only in IDLE, then follow the owner's
  // AR handshake followed by its R handshake.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (lsu_arvalid && ifu_arvalid) begin
          if (streak_q == STARVE_LIM) begin
            state_d  = IFU_AR;
            streak_d = 4'd0;
          end else begin
            state_d  = LSU_AR;
            streak_d = (streak_q < STARVE_LIM) ? streak_q + 4'd1 : STARVE_LIM;
          end
        end else if (lsu_arvalid) begin
          // uncontested LSU grant: the IFU was not waiting, so the streak resets
          state_d  = LSU_AR;
          streak_d = 4'd0;
        end else if (ifu_arvalid) begin
          state_d  = IFU_AR;
          streak_d = 4'd0;
        end
      end
      IFU_AR: if (ifu_arvalid && s_arready) state_d = IFU_R;
      IFU_R:  if (s_rvalid && ifu_rready)   state_d = IDLE;
      LSU_AR: if (lsu_arvalid && s_arready) state_d = LSU_R;
      LSU_R:  if (s_rvalid && lsu_rready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel steering: outputs are pure decode of state plus the owner's inputs.
  always_comb begin
    s_arvalid   = 1'b0;
    s_araddr    = 64'd0;
    s_rready    = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    grant_o     = 2'b00;
    case (state_q)
      IFU_AR: begin
        s_arvalid   = ifu_arvalid;
        s_araddr    = ifu_araddr;
        ifu_arready = s_arready;
        grant_o     = 2'b01;
      end
      IFU_R: begin
        s_rready   = ifu_rready;
        ifu_rvalid = s_rvalid;
        grant_o    = 2'b01;
      end
      LSU_AR: begin
        s_arvalid   = lsu_arvalid;
        s_araddr    = lsu_araddr;
        lsu_arready = s_arready;
        grant_o     = 2'b10;
      end
      LSU_R: begin
        s_rready   = lsu_rready;
        lsu_rvalid = s_rvalid;
        grant_o    = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data and response fan out to both masters; only rvalid qualifies them.
  assign ifu_rdata = s_rdata;
  assign ifu_rresp = s_rresp;
  assign lsu_rdata = s_rdata;
  assign lsu_rresp = s_rresp;

endmodule

// File: tb/tb_ysyx_22050019_rd_arbiter.sv
// Testbench for the two-master read arbiter: a vector table of transactions,
// a scoreboard of expected R beats, and a hand-written mid-transaction reset.
module tb_ysyx_22050019_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [63:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [63:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  ysyx_22050019_rd_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .grant_o(grant_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0]  who;
    logic [63:0] data;
    logic [1:0]  resp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [63:0] ifu_a;
    logic [63:0] lsu_a;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    int          rr_wait;
    logic [1:0]  exp_g;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic lv, input logic [63:0] ia,
                              input logic [63:0] la, input logic [63:0] rd, input logic [1:0] rs,
                              input int aw, input int rw, input int rrw, input logic [1:0] g);
    vec_t v;
    v.ifu_v = iv; v.lsu_v = lv; v.ifu_a = ia; v.lsu_a = la;
    v.rdata = rd; v.rresp = rs; v.ar_wait = aw; v.r_wait = rw; v.rr_wait = rrw; v.exp_g = g;
    return v;
  endfunction

  // Scoreboard: every completed R handshake on either master must match the
  // oldest expected beat.
  always @(negedge clk) begin
    if (!rst_n && ((ifu_rvalid && ifu_rready) || (lsu_rvalid && lsu_rready))) begin
      chk("sb_single_rvalid", 64'(ifu_rvalid & lsu_rvalid), 64'd0);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (ifu_rvalid) begin
          chk("sb_owner", 64'(2'b01), 64'(e.who));
          chk("sb_ifu_rdata", ifu_rdata, e.data);
          chk("sb_ifu_rresp", 64'(ifu_rresp), 64'(e.resp));
        end else begin
          chk("sb_owner", 64'(2'b10), 64'(e.who));
          chk("sb_lsu_rdata", lsu_rdata, e.data);
          chk("sb_lsu_rresp", 64'(lsu_rresp), 64'(e.resp));
        end
      end
    end
  end

  task automatic run_txn(input int idx, input vec_t v);
    logic [63:0] wa;
    sb_t e;
    ifu_arvalid = v.ifu_v; lsu_arvalid = v.lsu_v;
    ifu_araddr = v.ifu_a;  lsu_araddr = v.lsu_a;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0;
    #1;
    chk($sformatf("v%0d_idle_grant", idx), 64'(grant_o), 64'd0);
    chk($sformatf("v%0d_idle_s_arvalid", idx), 64'(s_arvalid), 64'd0);
    tick;
    wa = (v.exp_g == 2'b01) ? v.ifu_a : v.lsu_a;
    chk($sformatf("v%0d_ar_grant", idx), 64'(grant_o), 64'(v.exp_g));
    chk($sformatf("v%0d_ar_s_arvalid", idx), 64'(s_arvalid), 64'd1);
    chk($sformatf("v%0d_ar_s_araddr", idx), s_araddr, wa);
    if (v.exp_g == 2'b01) chk($sformatf("v%0d_loser_arready", idx), 64'(lsu_arready), 64'd0);
    else                  chk($sformatf("v%0d_loser_arready", idx), 64'(ifu_arready), 64'd0);
    e.who = v.exp_g; e.data = v.rdata; e.resp = v.rresp;
    sb_q.push_back(e);
    for (int i = 0; i < v.ar_wait; i++) begin
      tick;
      chk($sformatf("v%0d_arhold_grant", idx), 64'(grant_o), 64'(v.exp_g));
      chk($sformatf("v%0d_arhold_valid", idx), 64'(s_arvalid), 64'd1);
      chk($sformatf("v%0d_arhold_addr", idx), s_araddr, wa);
    end
    s_arready = 1'b1;
    #1;
    if (v.exp_g == 2'b01) chk($sformatf("v%0d_owner_arready", idx), 64'(ifu_arready), 64'd1);
    else                  chk($sformatf("v%0d_owner_arready", idx), 64'(lsu_arready), 64'd1);
    tick;
    s_arready = 1'b0;
    if (v.exp_g == 2'b01) ifu_arvalid = 1'b0; else lsu_arvalid = 1'b0;
    for (int i = 0; i < v.r_wait; i++) tick;
    s_rvalid = 1'b1; s_rdata = v.rdata; s_rresp = v.rresp;
    if (v.exp_g == 2'b01) ifu_rready = (v.rr_wait == 0); else lsu_rready = (v.rr_wait == 0);
    #1;
    chk($sformatf("v%0d_r_grant", idx), 64'(grant_o), 64'(v.exp_g));
    if (v.exp_g == 2'b01) begin
      chk($sformatf("v%0d_ifu_rvalid", idx), 64'(ifu_rvalid), 64'd1);
      chk($sformatf("v%0d_lsu_rvalid_low", idx), 64'(lsu_rvalid), 64'd0);
    end else begin
      chk($sformatf("v%0d_lsu_rvalid", idx), 64'(lsu_rvalid), 64'd1);
      chk($sformatf("v%0d_ifu_rvalid_low", idx), 64'(ifu_rvalid), 64'd0);
    end
    for (int i = 0; i < v.rr_wait; i++) begin
      chk($sformatf("v%0d_rhold_s_rready", idx), 64'(s_rready), 64'd0);
      tick;
      chk($sformatf("v%0d_rhold_grant", idx), 64'(grant_o), 64'(v.exp_g));
    end
    if (v.exp_g == 2'b01) ifu_rready = 1'b1; else lsu_rready = 1'b1;
    #1;
    chk($sformatf("v%0d_s_rready", idx), 64'(s_rready), 64'd1);
    tick;
    s_rvalid = 1'b0;
    #1;
    chk($sformatf("v%0d_done_grant", idx), 64'(grant_o), 64'd0);
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_grant"}, 64'(grant_o), 64'd0);
    chk({tag, "_s_arvalid"}, 64'(s_arvalid), 64'd0);
    chk({tag, "_s_araddr"}, s_araddr, 64'd0);
    chk({tag, "_s_rready"}, 64'(s_rready), 64'd0);
    chk({tag, "_arreadys"}, 64'({ifu_arready, lsu_arready}), 64'd0);
    chk({tag, "_rvalids"}, 64'({ifu_rvalid, lsu_rvalid}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seg1;
    // Vector table: {ifu_v, lsu_v, ifu_a, lsu_a, rdata, rresp, ar_wait, r_wait, rr_wait, grant}
    vecs.push_back(mk(1, 0, 64'h8000_0000, 64'h0, 64'h0000_0013_0000_0093, 2'b00, 0, 2, 0, 2'b01));
    // both held high: L L L L I L L L L I
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 1, 64'h8000_0100 + 64'(i * 4), 64'h8000_1000 + 64'(i * 8),
                        64'hA5A5_0000_0000_0000 + 64'(i), 2'b00, 0, 0, 0,
                        (i == 4 || i == 9) ? 2'b01 : 2'b10));
    // LSU alone three times keeps the streak at zero
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 64'h0, 64'h8000_2000 + 64'(i * 8), 64'h1111_0000_0000_0000 + 64'(i),
                        2'b00, 0, 1, 0, 2'b10));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 64'h8000_0200 + 64'(i * 4), 64'h8000_3000 + 64'(i * 8),
                        64'h2222_0000_0000_0000 + 64'(i), 2'b00, 0, 0, 0,
                        (i == 4) ? 2'b01 : 2'b10));
    // backpressure on both AR and R
    vecs.push_back(mk(0, 1, 64'h0, 64'h8000_4000, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 5, 1, 3, 2'b10));
    // error response, then a normal IFU read
    vecs.push_back(mk(0, 1, 64'h0, 64'h1000_0000, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, 0, 0, 0, 2'b10));
    vecs.push_back(mk(1, 0, 64'h8000_0300, 64'h0, 64'h0000_0000_0000_0073, 2'b00, 0, 1, 0, 2'b01));
    // build streak to 3 before the mid-transaction reset
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1, 64'h8000_0400 + 64'(i * 4), 64'h8000_5000 + 64'(i * 8),
                        64'h3333_0000_0000_0000 + 64'(i), 2'b01, 0, 0, 0, 2'b10));
    seg1 = vecs.size();
    // after reset: streak must be zero again
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 64'h8000_0500 + 64'(i * 4), 64'h8000_6000 + 64'(i * 8),
                        64'h4444_0000_0000_0000 + 64'(i), 2'b00, 0, 0, 0,
                        (i == 4) ? 2'b01 : 2'b10));
    vecs.push_back(mk(1, 0, 64'h8000_0600, 64'h0, 64'h5555_6666_7777_8888, 2'b00, 1, 2, 1, 2'b01));

    // Reset with a pending IFU request: nothing may be granted while held.
    rst_n = 1'b1;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b0;
    ifu_araddr = 64'h8000_0000; lsu_araddr = 64'h0;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 64'h0; s_rresp = 2'b00;
    repeat (3) tick;
    chk_all_quiet("reset");
    ifu_arvalid = 1'b0;
    rst_n = 1'b0;
    tick;

    for (int i = 0; i < seg1; i++) run_txn(i, vecs[i]);

    // Contested LSU grant (streak -> 4), then reset in LSU_R before s_rvalid.
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    ifu_araddr = 64'h8000_0700; lsu_araddr = 64'h8000_7000;
    tick;
    chk("rst_seq_ar_grant", 64'(grant_o), 64'(2'b10));
    chk("rst_seq_s_araddr", s_araddr, 64'h8000_7000);
    s_arready = 1'b1;
    tick;
    s_arready = 1'b0; lsu_arvalid = 1'b0; ifu_arvalid = 1'b0;
    #1;
    chk("rst_seq_r_grant", 64'(grant_o), 64'(2'b10));
    chk("rst_seq_r_s_rready", 64'(s_rready), 64'd1);
    rst_n = 1'b1;
    tick;
    chk_all_quiet("midreset");
    rst_n = 1'b0;

    for (int i = seg1; i < vecs.size(); i++) run_txn(i, vecs[i]);

    repeat (2) tick;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
